// File: rtl/ones_generator_if.sv
// Density handshake and bitstream bundle for ones_generator.
// Handshake: a density transfers on any posedge where density_valid && density_ready.
interface ones_generator_if #(
  parameter int W = 11
) ();
  logic [W-1:0] density_in;
  logic         density_valid;
  logic         density_ready;
  logic         pulse;
  logic         frame_start;
  logic [W-1:0] level;

  modport master (
    output density_in, density_valid,
    input  density_ready, pulse, frame_start, level
  );

  modport slave (
    input  density_in, density_valid,
    output density_ready, pulse, frame_start, level
  );
endinterface

// File: rtl/ones_generator.sv
// Pulse-density generator: exactly `level` ones per frame of NUMBER_OF_SAMPLES slots.
// ONES_GEN_SPREAD_EN selects error-feedback spreading; otherwise a burst pattern.
module ones_generator #(
  parameter int NUMBER_OF_SAMPLES = 2047
) (
  input  logic            clk,
  input  logic            rst,
  ones_generator_if.slave bus
);
  localparam int N = NUMBER_OF_SAMPLES;
  localparam int W = $clog2(N + 1);
  localparam int C = $clog2(N);
  localparam logic [C-1:0] LAST = C'(N - 1);
  localparam logic [W-1:0] NW   = W'(N);

  logic [C-1:0] slot, slot_next;
  logic [W-1:0] active, active_next;
  logic [W-1:0] pend, pend_next;
  logic         pend_full, pend_full_next;
  logic [W-1:0] sat;
  logic         boundary, hs;
  logic         pulse_next, frame_start_next;

  assign bus.density_ready = !pend_full;

  always_comb begin
    boundary       = (slot == LAST);
    hs             = bus.density_valid && !pend_full;
    sat            = (bus.density_in > NW) ? NW : bus.density_in;
    slot_next      = boundary ? '0 : slot + C'(1);
    active_next    = active;
    pend_next      = pend;
    pend_full_next = pend_full;
    if (boundary) begin
      // At the boundary a queued value wins; otherwise a same-cycle accept bypasses.
      pend_full_next = 1'b0;
      if (pend_full) begin
        active_next = pend;
      end else if (hs) begin
        active_next = sat;
      end
    end else if (hs) begin
      pend_next      = sat;
      pend_full_next = 1'b1;
    end
    frame_start_next = (slot_next == '0);
  end

`ifdef ONES_GEN_SPREAD_EN
  logic [W:0] acc, acc_next, acc_base, t;

  always_comb begin
    acc_base = (slot_next == '0) ? '0 : acc;
    t        = acc_base + {1'b0, active_next};
    if (t >= {1'b0, NW}) begin
      pulse_next = 1'b1;
      acc_next   = t - {1'b0, NW};
    end else begin
      pulse_next = 1'b0;
      acc_next   = t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end
`else
  always_comb begin
    pulse_next = (W'(slot_next) < active_next);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      slot            <= '0;
      active          <= '0;
      pend            <= '0;
      pend_full       <= 1'b0;
      bus.pulse       <= 1'b0;
      bus.frame_start <= 1'b1;
      bus.level       <= '0;
    end else begin
      slot            <= slot_next;
      active          <= active_next;
      pend            <= pend_next;
      pend_full       <= pend_full_next;
      bus.pulse       <= pulse_next;
      bus.frame_start <= frame_start_next;
      bus.level       <= active_next;
    end
  end
endmodule

// File: tb/tb_ones_generator.sv
// Bench for ones_generator: per-cycle behavioural model on N=8, frame ones-count sweep on N=2047.
module tb_ones_generator;
  localparam int N_S = 8;
  localparam int W_S = $clog2(N_S + 1);
  localparam int N_B = 2047;
  localparam int W_B = $clog2(N_B + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ones_generator_if #(.W(W_S)) s_bus ();
  ones_generator_if #(.W(W_B)) b_bus ();

  ones_generator #(.NUMBER_OF_SAMPLES(N_S)) u_small (.clk(clk), .rst(rst), .bus(s_bus));
  ones_generator #(.NUMBER_OF_SAMPLES(N_B)) u_big   (.clk(clk), .rst(rst), .bus(b_bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (small DUT) ----------------
  function automatic logic exp_pulse(input int d, input int s);
`ifdef ONES_GEN_SPREAD_EN
    return (((s + 1) * d) / N_S) > ((s * d) / N_S);
`else
    return s < d;
`endif
  endfunction

  function automatic logic [W_S-1:0] sat_s(input logic [W_S-1:0] d);
    return (int'(d) > N_S) ? W_S'(N_S) : d;
  endfunction

  logic [W_S-1:0] exp_q[$];
  int             m_slot   = 0;
  int             m_active = 0;
  bit             m_on     = 0;
  logic [N_S-1:0] frame_bits, last_frame;

  always @(posedge clk) begin
    if (rst) begin
      m_slot   = 0;
      m_active = 0;
      exp_q.delete();
      m_on     = 1;
    end else if (m_on) begin
      if (s_bus.density_valid && exp_q.size() == 0) exp_q.push_back(sat_s(s_bus.density_in));
      if (m_slot == N_S - 1) begin
        m_slot = 0;
        if (exp_q.size() > 0) m_active = int'(exp_q.pop_front());
      end else begin
        m_slot++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("ready", 32'(s_bus.density_ready), 32'(exp_q.size() == 0));
      check("pulse", 32'(s_bus.pulse), 32'(exp_pulse(m_active, m_slot)));
      check("frame_start", 32'(s_bus.frame_start), 32'(m_slot == 0));
      check("level", 32'(s_bus.level), 32'(m_active));
      frame_bits[m_slot] = s_bus.pulse;
      if (m_slot == N_S - 1) last_frame = frame_bits;
    end
  end

  // ---------------- frame counter (big DUT) ----------------
  int b_slot = 0;
  int b_cnt  = 0;
  int b_last = 0;
  bit b_on   = 0;

  always @(posedge clk) begin
    if (rst) begin
      b_slot = 0;
      b_on   = 1;
    end else if (b_on) begin
      b_slot = (b_slot == N_B - 1) ? 0 : b_slot + 1;
    end
  end

  always @(negedge clk) begin
    if (b_on && !rst) begin
      check("big_frame_start", 32'(b_bus.frame_start), 32'(b_slot == 0));
      b_cnt = (b_slot == 0) ? int'(b_bus.pulse) : b_cnt + int'(b_bus.pulse);
      if (b_slot == N_B - 1) b_last = b_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_slot(input int s);
    int n = 0;
    while (m_slot != s && n < 4 * N_S) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_slot != s) check("wait_slot_timeout", 32'(m_slot), 32'(s));
  endtask

  task automatic frame_end();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (m_slot != N_S - 1 && n < 4 * N_S);
    if (m_slot != N_S - 1) check("frame_end_timeout", 32'(m_slot), 32'(N_S - 1));
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic [W_S-1:0] d, output int slot_at);
    int n = 0;
    bit done = 0;
    slot_at = -1;
    s_bus.density_valid = 1'b1;
    s_bus.density_in    = d;
    while (!done && n < 4 * N_S) begin
      if (s_bus.density_ready) begin
        slot_at = m_slot;
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    s_bus.density_valid = 1'b0;
    if (!done) check("drive_timeout", 32'(done), 32'd1);
  endtask

  task automatic b_frame_end();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (b_slot != N_B - 1 && n < 3 * N_B);
    if (b_slot != N_B - 1) check("big_frame_end_timeout", 32'(b_slot), 32'(N_B - 1));
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic [N_S-1:0] exp1;
    int d4[3]   = '{0, 8, 15};
    int e4[3]   = '{0, 8, 8};
    int db[5]   = '{0, 1, 1023, 2046, 2047};
`ifdef ONES_GEN_SPREAD_EN
    exp1 = 8'b1010_0100;
`else
    exp1 = 8'b0000_0111;
`endif
    s_bus.density_valid = 1'b0;
    s_bus.density_in    = '0;
    b_bus.density_valid = 1'b0;
    b_bus.density_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Write 3 in slot 2: frame 0 silent, frame 1 carries 3 ones.
    wait_slot(2);
    drive(W_S'(3), s);
    check("t1_accept_slot", 32'(s), 32'd2);
    frame_end();
    check("t1_frame0", 32'(last_frame), 32'd0);
    frame_end();
    check("t1_pattern", 32'(last_frame), 32'(exp1));
    check("t1_level", 32'(s_bus.level), 32'd3);

    // Back-to-back writes: second stalls until slot 0.
    wait_slot(1);
    drive(W_S'(5), s);
    check("t2_stall_ready", 32'(s_bus.density_ready), 32'd0);
    drive(W_S'(2), s);
    check("t2_second_slot", 32'(s), 32'd0);
    frame_end();
    check("t2_count5", 32'($countones(last_frame)), 32'd5);
    frame_end();
    check("t2_count2", 32'($countones(last_frame)), 32'd2);

    // Bypass at the boundary slot.
    wait_slot(N_S - 1);
    drive(W_S'(6), s);
    check("t3_accept_slot", 32'(s), 32'(N_S - 1));
    check("t3_level_now", 32'(s_bus.level), 32'd6);
    frame_end();
    check("t3_count6", 32'($countones(last_frame)), 32'd6);

    // Extremes and saturation.
    for (int i = 0; i < 3; i++) begin
      wait_slot(1);
      drive(W_S'(d4[i]), s);
      frame_end();
      frame_end();
      check("t4_count", 32'($countones(last_frame)), 32'(e4[i]));
      check("t4_level", 32'(s_bus.level), 32'(e4[i]));
    end

    // Reset mid-frame with a queued value.
    wait_slot(1);
    drive(W_S'(4), s);
    frame_end();
    wait_slot(1);
    drive(W_S'(7), s);
    check("t5_pend_full", 32'(s_bus.density_ready), 32'd0);
    wait_slot(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_pulse", 32'(s_bus.pulse), 32'd0);
    check("t5_rst_fs", 32'(s_bus.frame_start), 32'd1);
    check("t5_rst_level", 32'(s_bus.level), 32'd0);
    check("t5_rst_ready", 32'(s_bus.density_ready), 32'd1);
    frame_end();
    check("t5_frame0", 32'(last_frame), 32'd0);
    frame_end();
    check("t5_queued_lost", 32'(last_frame), 32'd0);

    // Random traffic, checked by the per-cycle model.
    repeat (400) begin
      @(posedge clk); #1;
      s_bus.density_valid = ($urandom_range(0, 2) == 0);
      s_bus.density_in    = W_S'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    s_bus.density_valid = 1'b0;

    // Large frame sweep: ones per frame equal the density of that frame.
    for (int i = 0; i < 5; i++) begin
      while (b_slot != 1) begin
        @(posedge clk); #1;
      end
      b_bus.density_valid = 1'b1;
      b_bus.density_in    = W_B'(db[i]);
      @(posedge clk); #1;
      b_bus.density_valid = 1'b0;
      b_frame_end();
      b_frame_end();
      check("big_count", 32'(b_last), 32'(db[i]));
      check("big_level", 32'(b_bus.level), 32'(db[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
